// File: rtl/imm_encoder.sv
// Immediate encoder: inverse of the immediate generator. Places an immediate into
// an instruction template, flags unrepresentable values, and can split I-type into LUI + I.
module imm_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_inst_i,
    input  logic [3:0]  in_sel_i,
    input  logic [31:0] in_imm_i,
    input  logic        expand_en_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_inst_o,
    output logic [6:0]  out_imm_ext_o,
    output logic        out_err_o,
    output logic        out_last_o,
    output logic [15:0] err_cnt_o
);

    localparam logic [3:0] SEL_I   = 4'd0;
    localparam logic [3:0] SEL_S   = 4'd1;
    localparam logic [3:0] SEL_B   = 4'd2;
    localparam logic [3:0] SEL_U   = 4'd3;
    localparam logic [3:0] SEL_J   = 4'd4;
    localparam logic [3:0] SEL_Z   = 4'd5;
    localparam logic [3:0] SEL_2   = 4'd6;
    localparam logic [3:0] SEL_L11 = 4'd7;
    localparam logic [3:0] SEL_S11 = 4'd8;
    localparam logic [3:0] SEL_V   = 4'd9;

    localparam logic [6:0] OPC_LUI = 7'b0110111;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    // True when v[31:lo] are all equal, i.e. v is a sign extension of v[lo:0].
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned lo);
        logic [31:0] t;
        t = 32'($signed(v) >>> lo);
        return (t == 32'h0000_0000) || (t == 32'hFFFF_FFFF);
    endfunction

    state_t      state_r, state_n;
    logic        out_valid_r, out_valid_n;
    logic [31:0] out_inst_r, out_inst_n;
    logic [6:0]  out_ext_r, out_ext_n;
    logic        out_err_r, out_err_n;
    logic        out_last_r, out_last_n;
    logic [15:0] err_cnt_r, err_cnt_n;
    logic [31:0] pend_inst_r, pend_inst_n;

    logic [31:0] enc_inst_s;
    logic [6:0]  enc_ext_s;
    logic        enc_err_s;
    logic        expand_s;
    logic        accept_s;
    logic [31:0] lui_sum_s;
    logic [31:0] lui_inst_s;
    logic [31:0] beat2_inst_s;

    // Single-word field placement and representability check for every format.
    always_comb begin
        enc_inst_s = in_inst_i;
        enc_ext_s  = 7'b000_0000;
        enc_err_s  = 1'b0;
        case (in_sel_i)
            SEL_I: begin
                enc_inst_s[31:20] = in_imm_i[11:0];
                enc_err_s         = !fits_signed(in_imm_i, 32'd11);
            end
            SEL_S: begin
                enc_inst_s[31:25] = in_imm_i[11:5];
                enc_inst_s[11:7]  = in_imm_i[4:0];
                enc_err_s         = !fits_signed(in_imm_i, 32'd11);
            end
            SEL_B: begin
                enc_inst_s[31]    = in_imm_i[12];
                enc_inst_s[7]     = in_imm_i[11];
                enc_inst_s[30:25] = in_imm_i[10:5];
                enc_inst_s[11:8]  = in_imm_i[4:1];
                enc_err_s         = in_imm_i[0] || !fits_signed(in_imm_i, 32'd12);
            end
            SEL_U: begin
                enc_inst_s[31:12] = in_imm_i[31:12];
                enc_err_s         = (in_imm_i[11:0] != 12'h000);
            end
            SEL_J: begin
                enc_inst_s[31]    = in_imm_i[20];
                enc_inst_s[19:12] = in_imm_i[19:12];
                enc_inst_s[20]    = in_imm_i[11];
                enc_inst_s[30:21] = in_imm_i[10:1];
                enc_err_s         = in_imm_i[0] || !fits_signed(in_imm_i, 32'd20);
            end
            SEL_Z: begin
                enc_inst_s[19:15] = in_imm_i[4:0];
                enc_err_s         = (in_imm_i[31:5] != 27'd0);
            end
            SEL_2: begin
                enc_inst_s[24:20] = in_imm_i[4:0];
                enc_err_s         = !fits_signed(in_imm_i, 32'd4);
            end
            SEL_L11: begin
                enc_inst_s[30:20] = in_imm_i[10:0];
                enc_err_s         = !fits_signed(in_imm_i, 32'd10);
            end
            SEL_S11: begin
                enc_inst_s[30:25] = in_imm_i[10:5];
                enc_inst_s[11:7]  = in_imm_i[4:0];
                enc_err_s         = !fits_signed(in_imm_i, 32'd10);
            end
            SEL_V: begin
                enc_inst_s[19:15] = in_imm_i[4:0];
                if (fits_signed(in_imm_i, 32'd4)) begin
                    enc_ext_s = 7'b000_0000;
                end else if (fits_signed(in_imm_i, 32'd10)) begin
                    enc_ext_s = {1'b1, in_imm_i[10:5]};
                end else begin
                    enc_err_s = 1'b1;
                end
            end
            default: begin
                // masked-I: odd positive values are reserved
                enc_inst_s[31:20] = in_imm_i[11:0];
                enc_err_s         = !fits_signed(in_imm_i, 32'd11) ||
                                    (!in_imm_i[31] && in_imm_i[0]);
            end
        endcase
    end

    // LUI + I split; the +0x800 compensates for the sign of the low 12 bits.
    always_comb begin
        lui_sum_s    = in_imm_i + 32'h0000_0800;
        lui_inst_s   = {lui_sum_s[31:12], in_inst_i[11:7], OPC_LUI};
        beat2_inst_s = {in_imm_i[11:0], in_inst_i[19:0]};
        expand_s     = (in_sel_i == SEL_I) && expand_en_i &&
                       (in_inst_i[11:7] != 5'd0) && !fits_signed(in_imm_i, 32'd11);
    end

    assign in_ready_o = !rst && (state_r == ST_IDLE) && (!out_valid_r || out_ready_i);
    assign accept_s   = in_valid_i && in_ready_o;

    // Next-state and next-output logic for the two-beat handshake FSM.
    always_comb begin
        state_n     = state_r;
        out_valid_n = out_valid_r;
        out_inst_n  = out_inst_r;
        out_ext_n   = out_ext_r;
        out_err_n   = out_err_r;
        out_last_n  = out_last_r;
        err_cnt_n   = err_cnt_r;
        pend_inst_n = pend_inst_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    out_valid_n = 1'b1;
                    if (expand_s) begin
                        out_inst_n  = lui_inst_s;
                        out_ext_n   = 7'b000_0000;
                        out_err_n   = 1'b0;
                        out_last_n  = 1'b0;
                        pend_inst_n = beat2_inst_s;
                        state_n     = ST_SECOND;
                    end else begin
                        out_inst_n = enc_inst_s;
                        out_ext_n  = enc_ext_s;
                        out_err_n  = enc_err_s;
                        out_last_n = 1'b1;
                        if (enc_err_s && (err_cnt_r != 16'hFFFF)) begin
                            err_cnt_n = err_cnt_r + 16'd1;
                        end else begin
                            err_cnt_n = err_cnt_r;
                        end
                    end
                end else if (out_ready_i) begin
                    out_valid_n = 1'b0;
                end else begin
                    out_valid_n = out_valid_r;
                end
            end
            ST_SECOND: begin
                if (out_ready_i) begin
                    if (!out_last_r) begin
                        out_inst_n  = pend_inst_r;
                        out_ext_n   = 7'b000_0000;
                        out_err_n   = 1'b0;
                        out_last_n  = 1'b1;
                        out_valid_n = 1'b1;
                    end else begin
                        out_valid_n = 1'b0;
                        state_n     = ST_IDLE;
                    end
                end else begin
                    state_n = ST_SECOND;
                end
            end
            default: begin
                state_n     = ST_IDLE;
                out_valid_n = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            out_inst_r  <= 32'h0000_0000;
            out_ext_r   <= 7'b000_0000;
            out_err_r   <= 1'b0;
            out_last_r  <= 1'b0;
            err_cnt_r   <= 16'h0000;
            pend_inst_r <= 32'h0000_0000;
        end else begin
            state_r     <= state_n;
            out_valid_r <= out_valid_n;
            out_inst_r  <= out_inst_n;
            out_ext_r   <= out_ext_n;
            out_err_r   <= out_err_n;
            out_last_r  <= out_last_n;
            err_cnt_r   <= err_cnt_n;
            pend_inst_r <= pend_inst_n;
        end
    end

    assign out_valid_o   = out_valid_r;
    assign out_inst_o    = out_inst_r;
    assign out_imm_ext_o = out_ext_r;
    assign out_err_o     = out_err_r;
    assign out_last_o    = out_last_r;
    assign err_cnt_o     = err_cnt_r;

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have port: clk  input  1  single clock, rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: in_valid_i  input  1  request valid.
REQ-004 SHALL have port: in_ready_o  output  1  request accepted when in_valid_i && in_ready_o.
REQ-005 SHALL have port: in_inst_i  input  32  instruction template; immediate fields ignored.
REQ-006 SHALL have port: in_sel_i  input  4  immediate format, using the `IMM_*` codes from define.v; codes 4'b1010-4'b1111 select the "masked-I" format.
REQ-007 SHALL have port: in_imm_i  input  32  immediate value to encode.
REQ-008 SHALL have port: expand_en_i  input  1  permits LUI expansion of out-of-range `IMM_I`.
REQ-009 SHALL have port: out_valid_o  output  1  output word valid.
REQ-010 SHALL have port: out_ready_i  input  1  downstream accepts the word.
REQ-011 SHALL have port: out_inst_o  output  32  encoded instruction word.
REQ-012 SHALL have port: out_imm_ext_o  output  7  extension word; bit6 = ext valid, bits5:0 = high immediate bits.
REQ-013 SHALL have port: out_err_o  output  1  immediate not representable; fields are truncated.
REQ-014 SHALL have port: out_last_o  output  1  last word of the request.
REQ-015 SHALL have port: err_cnt_o  output  16  count of accepted requests with error, saturating.

Function
REQ-016 Encoding SHALL be the exact inverse of the immediate generator. When out_err_o=0, decoding out_inst_o with the same sel and out_imm_ext_o SHALL return in_imm_i.
REQ-017 Field placement and representability by format:
- I: inst[31:20]=imm[11:0]; ok iff imm[31:11] are all equal.
- S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]; ok iff imm[31:11] are all equal.
- B: inst[31]=imm[12], inst[7]=imm[11], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1]; ok iff imm[0]=0 and imm[31:12] are all equal.
- U: inst[31:12]=imm[31:12]; ok iff imm[11:0]=0.
- J: inst[31]=imm[20], inst[19:12]=imm[19:12], inst[20]=imm[11], inst[30:21]=imm[10:1]; ok iff imm[0]=0 and imm[31:20] are all equal.
- Z: inst[19:15]=imm[4:0]; ok iff imm[31:5]=0.
- `IMM_2`: inst[24:20]=imm[4:0]; ok iff imm[31:4] are all equal.
- L11: inst[30:20]=imm[10:0]; inst[31] keeps the template bit; ok iff imm[31:10] are all equal.
- S11: inst[30:25]=imm[10:5], inst[11:7]=imm[4:0]; inst[31] keeps the template bit; ok iff imm[31:10] are all equal.
- masked-I: I placement; ok iff I-fit and (imm[31]=1 or imm[0]=0).
REQ-018 `IMM_V`:
- If imm[31:4] are all equal: inst[19:15]=imm[4:0], ext=7'b0.
- Else if imm[31:10] are all equal: inst[19:15]=imm[4:0], ext={1'b1, imm[10:5]}.
- Else: err=1.
- out_imm_ext_o SHALL be 7'b0 for every other format.
REQ-019 All template bits outside the selected fields SHALL pass through unchanged.
REQ-020 States SHALL be IDLE and SECOND. in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i).
REQ-021 Output SHALL be registered. An accepted request SHALL appear on out_* in the next cycle.
REQ-022 Expansion condition: sel=`IMM_I`, expand_en_i=1, template rd (bits 11:7) != 0, and imm not I-fit. Under this condition:
- Beat 1 SHALL be a LUI to rd with upper field = (imm+0x800)[31:12], mod 2^32; out_last_o=0, out_err_o=0.
- The FSM SHALL go to SECOND.
- Beat 2 SHALL be the template with inst[31:20]=imm[11:0] and out_last_o=1, presented in the cycle after beat 1 handshakes.
- The FSM SHALL return to IDLE on the beat-2 handshake.
REQ-023 A non-expanded request SHALL produce one word with out_last_o=1.
REQ-024 While out_valid_o=1 && out_ready_i=0, all out_* SHALL hold stable.
REQ-025 out_valid_o SHALL drop after the final handshake unless a new request is accepted in that same cycle. Back-to-back single-word throughput SHALL be 1 per cycle.
REQ-026 err_cnt_o SHALL increment by 1 per accepted erroneous request and saturate at 16'hFFFF.

Reset
REQ-027 While rst=1: out_valid_o=0, out_inst_o=0, out_imm_ext_o=0, out_err_o=0, out_last_o=0, err_cnt_o=0, state=IDLE.
REQ-028 in_ready_o SHALL be 0 while rst=1 and 1 in the first cycle after rst falls.
REQ-029 Reset asserted during SECOND SHALL discard beat 2.

Verification
REQ-030 `IMM_I`, imm=0xFFFFF800, template 0x00000293 -> one cycle later out_inst_o=0x80000293, err=0, last=1.
REQ-031 `IMM_I`, expand_en=1, imm=0x12345FFF, rd=5 -> beat 1 0x123462B7 (last=0), then beat 2 inst[31:20]=0xFFF (last=1); in_ready_o=0 between the beats.
REQ-032 `IMM_V` imm=0x3FF -> ext=7'h5F, inst[19:15]=5'h1F. imm=0xFFFFFFF0 -> ext=0, inst[19:15]=5'h10. imm=0x400 -> err=1.
REQ-033 sel=4'b1010: imm=0x3 -> err=1, err_cnt_o=1. imm=0xFFFFFFFF -> err=0, inst[31:20]=0xFFF.
REQ-034 out_ready_i=0 for 3 cycles -> out_* stable and in_ready_o=0; `IMM_U` imm=0x00001001 -> err=1.
REQ-035 rst pulsed during SECOND -> out_valid_o=0 and state=IDLE. Random roundtrip through the immediate generator SHALL match in_imm_i for all err=0 words.
